// File: rtl/uart_pkg.sv
// Shared UART TX definitions: data width, default bit period and sequencer states.
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int CLKS_PER_BIT_115200 = 434;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic calc_parity(input logic [UART_DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer_if.sv
// Host-side byte interface of the UART transmitter, plus the serial line and state debug view.
interface uart_tx_sequencer_if;
    import uart_pkg::*;

    // tx_start acts as valid and ~tx_busy as ready: a byte transfers on a posedge where
    // tx_start=1 and tx_busy=0. Requests while busy are dropped, never queued.
    logic                   tx_start;
    logic [UART_DATA_W-1:0] tx_data;
    logic                   tx_busy;
    logic                   tx_done;
    logic                   tx_out;
    state_e                 dbg_state;

    modport master (
        output tx_start, tx_data,
        input  tx_busy, tx_done, tx_out, dbg_state
    );

    modport slave (
        input  tx_start, tx_data,
        output tx_busy, tx_done, tx_out, dbg_state
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Free-running bit-period divider: one-cycle tick every CLKS_PER_BIT clocks, with synchronous clear.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic s_reset,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Clear suppresses a tick that would otherwise land on the same cycle.
    assign tick = ~clr & (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmitter: frames one byte per request (start, 8 data LSB first, optional parity, 1-2 stops).
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic                clk,
    input  logic                s_reset,
    uart_tx_sequencer_if.slave  tx_if
);

    localparam logic [3:0] LAST_DATA = 4'(UART_DATA_W - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_e                 state_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic [3:0]             bit_cnt_q;
    logic                   parity_q;
    logic                   tx_out_q;
    logic                   busy_q;
    logic                   done_q;

    logic accept;
    logic tick;

    // Accepting a byte restarts the bit timer so the start bit is a full period.
    assign accept = (state_q == S_IDLE) && tx_if.tx_start;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk     (clk),
        .s_reset (s_reset),
        .clr     (accept),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (s_reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx_out_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_if.tx_start) begin
                        shift_q   <= tx_if.tx_data;
                        parity_q  <= calc_parity(tx_if.tx_data, PARITY_ODD);
                        bit_cnt_q <= '0;
                        tx_out_q  <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx_out_q <= shift_q[0];
                        state_q  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            bit_cnt_q <= '0;
                            if (PARITY_EN) begin
                                tx_out_q <= parity_q;
                                state_q  <= S_PARITY;
                            end else begin
                                tx_out_q <= 1'b1;
                                state_q  <= S_STOP;
                            end
                        end else begin
                            // Bit 1 of the current register is the next bit on the line.
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            shift_q   <= shift_q >> 1;
                            tx_out_q  <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        tx_out_q <= 1'b1;
                        state_q  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    tx_out_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_if.tx_out    = tx_out_q;
    assign tx_if.tx_busy   = busy_q;
    assign tx_if.tx_done   = done_q;
    assign tx_if.dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: four configurations checked cycle by cycle against a frame-level model.
module tb_uart_tx_sequencer;
  import uart_pkg::*;

  // 0: C=4 no parity 1 stop, 1: C=4 even parity 2 stops, 2: C=434 no parity, 3: C=3 odd parity 1 stop
  localparam int P_C    [4] = '{4, 4, 434, 3};
  localparam int P_PAR  [4] = '{0, 1, 0, 1};
  localparam int P_ODD  [4] = '{0, 0, 0, 1};
  localparam int P_STOP [4] = '{1, 2, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v = 4'hF;
  logic [3:0] start_v = 4'h0;
  logic [7:0] data_v [4];
  logic [3:0] out_v, busy_v, done_v;
  logic [2:0] st_v [4];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  uart_tx_sequencer_if if_a ();
  uart_tx_sequencer_if if_b ();
  uart_tx_sequencer_if if_c ();
  uart_tx_sequencer_if if_d ();

  uart_tx_sequencer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1))
    dut_a (.clk(clk), .s_reset(rst_v[0]), .tx_if(if_a));
  uart_tx_sequencer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2))
    dut_b (.clk(clk), .s_reset(rst_v[1]), .tx_if(if_b));
  uart_tx_sequencer #(.CLKS_PER_BIT(434), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1))
    dut_c (.clk(clk), .s_reset(rst_v[2]), .tx_if(if_c));
  uart_tx_sequencer #(.CLKS_PER_BIT(3), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1))
    dut_d (.clk(clk), .s_reset(rst_v[3]), .tx_if(if_d));

  assign if_a.tx_start = start_v[0];
  assign if_b.tx_start = start_v[1];
  assign if_c.tx_start = start_v[2];
  assign if_d.tx_start = start_v[3];
  assign if_a.tx_data = data_v[0];
  assign if_b.tx_data = data_v[1];
  assign if_c.tx_data = data_v[2];
  assign if_d.tx_data = data_v[3];
  assign out_v[0] = if_a.tx_out;
  assign out_v[1] = if_b.tx_out;
  assign out_v[2] = if_c.tx_out;
  assign out_v[3] = if_d.tx_out;
  assign busy_v[0] = if_a.tx_busy;
  assign busy_v[1] = if_b.tx_busy;
  assign busy_v[2] = if_c.tx_busy;
  assign busy_v[3] = if_d.tx_busy;
  assign done_v[0] = if_a.tx_done;
  assign done_v[1] = if_b.tx_done;
  assign done_v[2] = if_c.tx_done;
  assign done_v[3] = if_d.tx_done;
  assign st_v[0] = if_a.dbg_state;
  assign st_v[1] = if_b.dbg_state;
  assign st_v[2] = if_c.dbg_state;
  assign st_v[3] = if_d.dbg_state;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int frame_bits(input int d);
    return 10 + P_PAR[d] + P_STOP[d] - 1;
  endfunction

  // Line image of a frame: bit i is the level during the i-th bit period; unused tail reads idle.
  function automatic logic [11:0] exp_line(input int d, input logic [7:0] b);
    logic [11:0] l;
    l = '1;
    l[0] = 1'b0;
    for (int i = 0; i < 8; i++) l[i+1] = b[i];
    if (P_PAR[d] != 0) l[9] = (P_ODD[d] != 0) ? ~^b : ^b;
    return l;
  endfunction

  // Reference model: per configuration, whether a frame is in flight and how many cycles into it.
  bit          m_act  [4];
  int          m_pos  [4];
  bit          m_done [4];
  logic [11:0] m_bits [4];
  int          m_len  [4];
  int          done_cnt [4];

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (chk_en) begin
        chk($sformatf("line%0d", d), 32'(out_v[d]),
            32'(m_act[d] ? m_bits[d][m_pos[d] / P_C[d]] : 1'b1));
        chk($sformatf("busy%0d", d), 32'(busy_v[d]), 32'(m_act[d]));
        chk($sformatf("done%0d", d), 32'(done_v[d]), 32'(m_done[d]));
        if (!m_act[d]) chk($sformatf("state%0d", d), 32'(st_v[d]), 32'(S_IDLE));
        if (done_v[d]) done_cnt[d] <= done_cnt[d] + 1;
      end
      m_done[d] <= 1'b0;
      if (rst_v[d]) begin
        m_act[d] <= 1'b0;
      end else if (m_act[d]) begin
        if (m_pos[d] + 1 == m_len[d] * P_C[d]) begin
          m_act[d]  <= 1'b0;
          m_done[d] <= 1'b1;
        end else begin
          m_pos[d] <= m_pos[d] + 1;
        end
      end else if (start_v[d]) begin
        m_act[d]  <= 1'b1;
        m_pos[d]  <= 0;
        m_bits[d] <= exp_line(d, data_v[d]);
        m_len[d]  <= frame_bits(d);
      end
    end
  end

  // Drives one request (unless start is already held) and watches the frame until tx_done.
  task automatic run_frame(input int d, input logic [7:0] b, input bit pre, input bit hold,
                           input logic [7:0] nb, input bit noise,
                           output int busy_cnt, output int done_edge, output logic [11:0] line);
    int c, len, pos;
    bit seen;
    c = P_C[d];
    len = frame_bits(d);
    busy_cnt = 0;
    done_edge = -1;
    line = '1;
    seen = 1'b0;
    if (!pre) begin
      @(posedge clk); #1;
      start_v[d] = 1'b1;
      data_v[d] = b;
    end
    for (int k = 1; k <= len * c + 4 && !seen; k++) begin
      @(posedge clk); #1;
      if (hold) begin
        start_v[d] = 1'b1;
        data_v[d] = nb;
      end else begin
        start_v[d] = noise && (k == 5 || k == 20);
        data_v[d] = noise ? ~b : 8'($urandom);
      end
      @(negedge clk);
      pos = k - 1;
      if (busy_v[d]) busy_cnt++;
      if ((pos % c) == (c / 2) && (pos / c) < len) line[pos / c] = out_v[d];
      if (done_v[d]) begin
        done_edge = k - 1;
        seen = 1'b1;
      end
    end
    if (!seen) chk($sformatf("done_timeout%0d", d), 32'd0, 32'd1);
  endtask

  task automatic frame(input int d, input logic [7:0] b, input bit pre, input bit hold,
                       input logic [7:0] nb, input bit noise, input string tag,
                       output int busy_cnt, output logic [11:0] line);
    int done_edge;
    int cyc;
    run_frame(d, b, pre, hold, nb, noise, busy_cnt, done_edge, line);
    cyc = frame_bits(d) * P_C[d];
    chk({tag, "_busy"}, busy_cnt, cyc);
    chk({tag, "_done_at"}, done_edge, cyc);
    chk({tag, "_bits"}, 32'(line), 32'(exp_line(d, b)));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int bcnt;
    int base;
    logic [11:0] line;
    logic [7:0] b, nb;
    bit pre, hold, noise;
    int dl [3] = '{0, 1, 3};

    for (int d = 0; d < 4; d++) data_v[d] = 8'h00;

    // Reset held 3 cycles, with a request on the last one that must be dropped.
    rst_v = 4'hF;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    start_v = 4'hF;
    for (int d = 0; d < 4; d++) data_v[d] = 8'($urandom);
    @(posedge clk); #1;
    rst_v = 4'h0;
    start_v = 4'h0;
    @(negedge clk);
    chk("rst_out", 32'(out_v), 32'hF);
    chk("rst_busy", 32'(busy_v), 32'h0);
    chk("rst_done", 32'(done_v), 32'h0);
    idle(50);
    for (int d = 0; d < 4; d++) chk($sformatf("rst_quiet%0d", d), done_cnt[d], 0);

    // Known frame 0xA5 on the 4-cycle link.
    frame(0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, "a5", bcnt, line);
    chk("a5_pattern", 32'(line[9:0]), 32'(10'b1101001010));
    chk("a5_busy40", bcnt, 40);

    // Even parity with 2 stop bits: 0x07 has three ones so the parity bit is 1.
    base = done_cnt[1];
    frame(1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, "p07", bcnt, line);
    chk("p07_parity", 32'(line[9]), 32'd1);
    chk("p07_busy48", bcnt, 48);
    idle(10);
    chk("p07_one_done", done_cnt[1] - base, 1);

    // Requests during a frame are ignored and change nothing.
    base = done_cnt[0];
    frame(0, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, "noise", bcnt, line);
    idle(30);
    chk("noise_one_frame", done_cnt[0] - base, 1);

    // Start held through tx_done: exactly one further frame, starting on the next edge.
    base = done_cnt[0];
    frame(0, 8'h81, 1'b0, 1'b1, 8'h5A, 1'b0, "hold1", bcnt, line);
    frame(0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, "hold2", bcnt, line);
    idle(30);
    chk("hold_two_frames", done_cnt[0] - base, 2);

    // Reset in the middle of the data bits.
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    data_v[0] = 8'h3C;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    idle(14);
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("midrst_line", 32'(out_v[0]), 32'd1);
    chk("midrst_busy", 32'(busy_v[0]), 32'd0);
    base = done_cnt[0];
    idle(50);
    chk("midrst_no_done", done_cnt[0] - base, 0);
    frame(0, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, "after_rst", bcnt, line);

    // Full-rate bit period.
    frame(2, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, "c434", bcnt, line);
    chk("c434_busy", bcnt, 4340);

    // Random traffic with gaps, mid-frame requests and held-start chains.
    for (int j = 0; j < 3; j++) begin
      pre = 1'b0;
      for (int i = 0; i < 15; i++) begin
        b = pre ? nb : 8'($urandom);
        hold = (i < 14) && ($urandom_range(0, 3) == 0);
        noise = !hold && ($urandom_range(0, 1) == 1);
        nb = 8'($urandom);
        frame(dl[j], b, pre, hold, nb, noise, $sformatf("rnd%0d_%0d", dl[j], i), bcnt, line);
        pre = hold;
        if (!hold) idle($urandom_range(0, 4));
      end
      start_v[dl[j]] = 1'b0;
      idle(5);
    end

    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
